// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// and flush that injects a bubble while preserving masked payload bits.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W          = 32,
  parameter logic [31:0]       NOP_VAL         = 32'h00000013,
  parameter logic [DATA_W-1:0] FLUSH_KEEP_MASK = '0,
  parameter bit                SKID_EN         = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and payload is only meaningful with valid.

  localparam logic [DATA_W-1:0] LP_NOP = DATA_W'(NOP_VAL);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_vld;
  logic                r_rdy;
  logic [1:0]          r_count;

  logic                w_rdy;
  logic                w_in;
  logic                w_out;
  logic                w_load_main;
  logic                w_main_from_skid;
  logic                w_load_skid;

  // Without skid, ready must look through to the downstream ready to keep throughput.
  assign w_rdy   = SKID_EN ? r_rdy : (!r_vld || i_rdy);
  assign w_in    = i_vld && w_rdy;
  assign w_out   = r_vld && i_rdy;

  assign o_rdy   = w_rdy;
  assign o_vld   = r_vld;
  assign o_data  = r_main;
  assign o_count = r_count;

  function automatic logic [1:0] count_of(input state_t s);
    case (s)
      ST_MAIN: count_of = 2'd1;
      ST_FULL: count_of = 2'd2;
      default: count_of = 2'd0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (w_in && w_out) begin
          w_load_main = 1'b1;
        end else if (w_in && SKID_EN) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_MAIN;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_main  <= LP_NOP;
      r_skid  <= LP_NOP;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
      r_count <= 2'd0;
    end else if (i_flush) begin
      // Any held skid entry is abandoned; its register value is simply never used.
      r_state <= ST_EMPTY;
      r_main  <= (r_main & FLUSH_KEEP_MASK) | (LP_NOP & ~FLUSH_KEEP_MASK);
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
      r_count <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : i_data;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
      r_vld   <= (w_state_nxt != ST_EMPTY);
      r_rdy   <= (w_state_nxt != ST_FULL);
      r_count <= count_of(w_state_nxt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance with a high-half keep mask,
// and a no-skid instance with the same mask.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush, vld, rdy;
  logic [31:0] data;
  logic        o_rdy, o_vld;
  logic [31:0] o_data;
  logic [1:0]  o_count;

  logic        z_flush, z_vld, z_rdy;
  logic [31:0] z_data;
  logic        z_o_rdy, z_o_vld;
  logic [31:0] z_o_data;
  logic [1:0]  z_o_count;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .NOP_VAL(32'h00000013),
    .FLUSH_KEEP_MASK(32'hFFFF0000), .SKID_EN(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_vld(vld), .o_rdy(o_rdy),
    .i_data(data), .o_vld(o_vld), .i_rdy(rdy), .o_data(o_data), .o_count(o_count)
  );

  pipe_stage_reg #(
    .DATA_W(32), .NOP_VAL(32'h00000013),
    .FLUSH_KEEP_MASK(32'hFFFF0000), .SKID_EN(1'b0)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(z_flush), .i_vld(z_vld), .o_rdy(z_o_rdy),
    .i_data(z_data), .o_vld(z_o_vld), .i_rdy(z_rdy), .o_data(z_o_data), .o_count(z_o_count)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // stim word: {flush, vld, rdy, data[31:0]}
  task automatic drive(input logic [34:0] s);
    flush = s[34];
    vld   = s[33];
    rdy   = s[32];
    data  = s[31:0];
  endtask

  // expected word: {vld, rdy, count[1:0], data[31:0]}; top nibble D=MAIN/ready,
  // A=FULL/not-ready, 4=EMPTY/ready
  task automatic test_reset();
    logic [35:0] got;
    rst = 1'b1;
    drive({3'b000, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'h4_00000013) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", got, 36'h4_00000013);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      got = {o_vld, o_rdy, o_count, o_data};
      checks++;
      if (got !== 36'h4_00000013) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, got, 36'h4_00000013);
      end
    end
  endtask

  task automatic test_streaming();
    logic [34:0] st[5];
    logic [35:0] ex[5];
    logic [35:0] got;
    st = '{{3'b011, 32'd1}, {3'b011, 32'd2}, {3'b011, 32'd3}, {3'b011, 32'd4},
           {3'b001, 32'd0}};
    ex = '{36'hD_00000001, 36'hD_00000002, 36'hD_00000003, 36'hD_00000004,
           36'h4_00000004};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      step();
      got = {o_vld, o_rdy, o_count, o_data};
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL stream[%0d]: got %h want %h", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [34:0] st[6];
    logic [35:0] ex[6];
    logic [35:0] got;
    st = '{{3'b011, 32'd10}, {3'b010, 32'd11}, {3'b010, 32'd12},
           {3'b011, 32'd12}, {3'b011, 32'd12}, {3'b001, 32'd0}};
    ex = '{36'hD_0000000A, 36'hA_0000000A, 36'hA_0000000A,
           36'hD_0000000B, 36'hD_0000000C, 36'h4_0000000C};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      step();
      got = {o_vld, o_rdy, o_count, o_data};
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL skid[%0d]: got %h want %h", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_flush_mask();
    logic [34:0] st[6];
    logic [35:0] ex[6];
    logic [35:0] got;
    st = '{{3'b010, 32'hABCD1234}, {3'b010, 32'h00000077}, {3'b100, 32'h0},
           {3'b001, 32'h0}, {3'b001, 32'h0}, {3'b001, 32'h0}};
    ex = '{36'hD_ABCD1234, 36'hA_ABCD1234, 36'h4_ABCD0013,
           36'h4_ABCD0013, 36'h4_ABCD0013, 36'h4_ABCD0013};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      step();
      got = {o_vld, o_rdy, o_count, o_data};
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL flush_mask[%0d]: got %h want %h", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_flush_collision();
    logic [34:0] st[6];
    logic [35:0] ex[6];
    logic [35:0] got;
    st = '{{3'b010, 32'h11112222}, {3'b110, 32'h00000055}, {3'b001, 32'h00000055},
           {3'b011, 32'h33334444}, {3'b111, 32'h00000055}, {3'b001, 32'h0}};
    ex = '{36'hD_11112222, 36'h4_11110013, 36'h4_11110013,
           36'hD_33334444, 36'h4_33330013, 36'h4_33330013};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      step();
      got = {o_vld, o_rdy, o_count, o_data};
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL flush_collide[%0d]: got %h want %h", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [35:0] got;
    drive({3'b010, 32'h000000A1});
    step();
    drive({3'b010, 32'h000000A2});
    step();
    drive({3'b000, 32'h0});
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'hA_000000A1) begin
      errors++;
      $display("FAIL arst_full: got %h want %h", got, 36'hA_000000A1);
    end
    #2 rst = 1'b1;
    #1;
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'h4_00000013) begin
      errors++;
      $display("FAIL arst_immediate: got %h want %h", got, 36'h4_00000013);
    end
    #1 rst = 1'b0;
    step();
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'h4_00000013) begin
      errors++;
      $display("FAIL arst_after: got %h want %h", got, 36'h4_00000013);
    end
    drive({3'b011, 32'h000000B5});
    step();
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'hD_000000B5) begin
      errors++;
      $display("FAIL arst_first_in: got %h want %h", got, 36'hD_000000B5);
    end
    drive({3'b001, 32'h0});
    step();
    got = {o_vld, o_rdy, o_count, o_data};
    checks++;
    if (got !== 36'h4_000000B5) begin
      errors++;
      $display("FAIL arst_drain: got %h want %h", got, 36'h4_000000B5);
    end
  endtask

  task automatic test_no_skid();
    logic [35:0] got;
    z_flush = 1'b0; z_vld = 1'b1; z_rdy = 1'b1; z_data = 32'h21;
    step();
    got = {z_o_vld, z_o_rdy, z_o_count, z_o_data};
    checks++;
    if (got !== 36'hD_00000021) begin
      errors++;
      $display("FAIL noskid_load: got %h want %h", got, 36'hD_00000021);
    end
    z_rdy = 1'b0; z_data = 32'h22;
    #1;
    checks++;
    if (z_o_rdy !== 1'b0) begin
      errors++;
      $display("FAIL noskid_rdy_low: got %b want 0", z_o_rdy);
    end
    step();
    got = {z_o_vld, z_o_rdy, z_o_count, z_o_data};
    checks++;
    if (got !== 36'h9_00000021) begin
      errors++;
      $display("FAIL noskid_stall: got %h want %h", got, 36'h9_00000021);
    end
    z_rdy = 1'b1;
    #1;
    checks++;
    if (z_o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL noskid_rdy_high: got %b want 1", z_o_rdy);
    end
    step();
    got = {z_o_vld, z_o_rdy, z_o_count, z_o_data};
    checks++;
    if (got !== 36'hD_00000022) begin
      errors++;
      $display("FAIL noskid_through: got %h want %h", got, 36'hD_00000022);
    end
    z_vld = 1'b0;
    step();
    got = {z_o_vld, z_o_rdy, z_o_count, z_o_data};
    checks++;
    if (got !== 36'h4_00000022) begin
      errors++;
      $display("FAIL noskid_drain: got %h want %h", got, 36'h4_00000022);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0; vld = 1'b0; rdy = 1'b0; data = 32'h0;
    z_flush = 1'b0; z_vld = 1'b0; z_rdy = 1'b0; z_data = 32'h0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_mask();
    test_flush_collision();
    test_async_reset();
    test_no_skid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
